mips_regfile_param: RTL
=======================

Name: mips_regfile_param

Overview:
- Parametrised successor to the MIPS general-purpose register file, used in the decode stage of the datapath.
- Two combinational read ports and one synchronous write port; width and depth are parameters.
- Adds optional hardwired zero register and a hardware clear sequencer after reset, replacing file preload.
- Adds a ready handshake, a dropped-write indication and an optional write-to-read bypass.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries (derived localparam)
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register
INIT_VALUE, 0, DATA_W-bit value loaded into every entry by the clear sweep

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
read_reg_1  input  ADDR_W  read port 1 index
read_reg_2  input  ADDR_W  read port 2 index
read_data_1  output  DATA_W  read port 1 data (combinational)
read_data_2  output  DATA_W  read port 2 data (combinational)
write_reg  input  ADDR_W  write index
write_data  input  DATA_W  write data
signal_reg_write  input  1  write enable, sampled on rising clk
ready  output  1  registered; 1 = file initialised, writes accepted
write_dropped  output  1  registered one-cycle pulse; a requested write was discarded

Behaviour:
- Single clock domain. Reset is synchronous and active-high: sampled only on the rising edge of clk.
- FSM states: CLEAR and RUN.
- Reset sampled high: state <= CLEAR, clr_idx <= 0, ready <= 0, write_dropped <= 0. Array contents are unchanged by the reset edge itself.
- CLEAR, each edge with reset low:
  - registers[clr_idx] <= INIT_VALUE; clr_idx <= clr_idx + 1.
  - On the edge where clr_idx == DEPTH-1: state <= RUN, ready <= 1.
  - ready is therefore high exactly DEPTH edges after the first edge with reset low.
- Reset asserted mid-sweep: sweep restarts at index 0 and ready stays 0.
- CLEAR, write requested (signal_reg_write=1): the write is discarded, array unchanged, write_dropped = 1 on the next cycle.
- CLEAR, reads: read_data_1 and read_data_2 are forced to 0 while ready = 0.
- RUN, signal_reg_write=1: registers[write_reg] <= write_data on the rising edge.
  - Exception: ZERO_REG=1 and write_reg == 0 → write ignored silently; write_dropped stays 0.
- RUN, reads: read_data_x = registers[read_reg_x]. When ZERO_REG=1 and read_reg_x == 0, read_data_x = 0 regardless of array content.
- Both ports may address the same index; each returns the same value.
- write_dropped is high for exactly one cycle per dropped request and is 0 in every other cycle.
- No X on outputs after the first reset edge. Array contents before the first sweep completes are don't-care.
- Clear sweep is a single write per cycle; no wide parallel reset of the array.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when ready=1, signal_reg_write=1, write_reg == read_reg_x, and the write is not suppressed by ZERO_REG, then read_data_x = write_data combinationally in the same cycle. This enables write-in-first-half / read-in-second-half pipeline semantics.
- Not defined: read_data_x returns the pre-write array value in the write cycle and the new value from the next cycle.
- In both builds, the zero-register and CLEAR-state forcing take priority over bypass.

Test Plan:
- Reset 2 cycles, then release; DEPTH=32, INIT_VALUE=0 → ready low for 32 edges, high on the 32nd. All 32 entries read 0.
- After ready: write reg 5 = 0xDEADBEEF; next cycle read_reg_1=5, read_reg_2=5 → both ports 0xDEADBEEF. Write reg 0 = 0x1234 → reg 0 reads 0, write_dropped stays 0.
- Write reg 7 = 0xA5A5A5A5 at cycle 3 of the sweep → write_dropped=1 for exactly one cycle, reg 7 reads INIT_VALUE after ready.
- Reset pulse at sweep index 10 → ready stays 0 and rises 32 edges after reset deasserts; entries previously written read INIT_VALUE.
- Same-cycle write reg 9 = 0x0000FFFF with read_reg_1=9:
  - REGFILE_BYPASS_EN defined → 0x0000FFFF that cycle.
  - Not defined → old value that cycle, 0x0000FFFF the next cycle.
- ZERO_REG=0, DATA_W=16, ADDR_W=3 → ready after 8 edges; write reg 0 = 0xBEEF reads back 0xBEEF; INIT_VALUE=0x1111 seen in all other entries.

Source files
------------

// File: rtl/mips_regfile_param.sv
// -----------------------------------------------------------------------------
// mips_regfile_param
//
// Parametrised MIPS general-purpose register file for the decode stage.
// Two combinational read ports, one synchronous write port. After reset a
// hardware sweep writes INIT_VALUE into every entry, one entry per cycle;
// 'ready' rises when the sweep finishes. Writes requested during the sweep are
// discarded and flagged on 'write_dropped' for one cycle.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined     -> a write to the index being read is forwarded to the read
//                  port in the same cycle (write-first / read-second).
//   not defined -> reads return the array contents; new data is visible the
//                  cycle after the write.
//
// Parameters:
//   DATA_W     register width in bits
//   ADDR_W     register index width, DEPTH = 2**ADDR_W
//   ZERO_REG   1 = entry 0 reads 0 and ignores writes
//   INIT_VALUE value loaded into every entry by the clear sweep
//
// Ports:
//   clk               rising-edge clock
//   reset             synchronous active-high reset
//   read_reg_1/2      read port indices
//   read_data_1/2     read port data (combinational, 0 while not ready)
//   write_reg         write index
//   write_data        write data
//   signal_reg_write  write enable
//   ready             registered, 1 once the clear sweep has completed
//   write_dropped     registered one-cycle pulse for each discarded write
// -----------------------------------------------------------------------------
module mips_regfile_param #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter int                ZERO_REG   = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              signal_reg_write,
    output logic              ready,
    output logic              write_dropped
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_next;
    logic              ready_q;
    logic              ready_next;
    logic              dropped_q;
    logic              dropped_next;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;

    logic [DATA_W-1:0] registers [DEPTH];

    logic              write_is_zero;
    logic              bypass_1;
    logic              bypass_2;

    // A write aimed at the hardwired zero entry is silently ignored; it is
    // not a "drop", so it never raises write_dropped.
    assign write_is_zero = (ZERO_REG != 0) && (write_reg == '0);

    // Next-state logic. The single array write port is shared: during CLEAR
    // it belongs to the sweep, during RUN to the user write. Requests that
    // arrive during CLEAR are reported as dropped on the following cycle.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        ready_next   = ready_q;
        dropped_next = 1'b0;
        arr_we       = 1'b0;
        arr_waddr    = write_reg;
        arr_wdata    = write_data;

        case (state)
            CLEAR: begin
                arr_we       = 1'b1;
                arr_waddr    = clr_idx;
                arr_wdata    = INIT_VALUE;
                clr_idx_next = clr_idx + 1'b1;
                dropped_next = signal_reg_write;
                if (clr_idx == LAST_IDX) begin
                    state_next = RUN;
                    ready_next = 1'b1;
                end
            end
            RUN: begin
                arr_we = signal_reg_write && !write_is_zero;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // Control registers. Reset restarts the sweep from index 0 wherever it
    // was; the array itself is not touched by the reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clr_idx   <= '0;
            ready_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state     <= state_next;
            clr_idx   <= clr_idx_next;
            ready_q   <= ready_next;
            dropped_q <= dropped_next;
        end
    end

    // Storage array: exactly one entry written per cycle, no parallel reset.
    always_ff @(posedge clk) begin
        if (!reset && arr_we) begin
            registers[arr_waddr] <= arr_wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign bypass_1 = ready_q && signal_reg_write && !write_is_zero && (write_reg == read_reg_1);
    assign bypass_2 = ready_q && signal_reg_write && !write_is_zero && (write_reg == read_reg_2);
`else
    assign bypass_1 = 1'b0;
    assign bypass_2 = 1'b0;
`endif

    // Read port 1. Not-ready and zero-register forcing are applied last so
    // they always win over the bypass.
    always_comb begin
        read_data_1 = registers[read_reg_1];
        if (bypass_1) begin
            read_data_1 = write_data;
        end
        if (!ready_q || ((ZERO_REG != 0) && (read_reg_1 == '0))) begin
            read_data_1 = '0;
        end
    end

    // Read port 2, same priority as port 1.
    always_comb begin
        read_data_2 = registers[read_reg_2];
        if (bypass_2) begin
            read_data_2 = write_data;
        end
        if (!ready_q || ((ZERO_REG != 0) && (read_reg_2 == '0))) begin
            read_data_2 = '0;
        end
    end

    assign ready         = ready_q;
    assign write_dropped = dropped_q;

endmodule
